// File: rtl/vga_timing_src.sv
// 640x480@60 VGA timing source with registered sync/position/strobe outputs and a packed pixel byte.
// Define VGA_PATTERN_EN to build the latched 2-bit test pattern generator; otherwise colour bits are 0.
module vga_timing_src #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_NEG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] pattern_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [7:0] frame_cnt,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] pix_byte
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic       SYNC_IDLE = (SYNC_NEG != 0);

  typedef enum logic {
    ST_PRESTART,
    ST_RUN
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] h_d, v_d;
  logic [7:0] f_d;
  logic       load;
  logic       hs_act, vs_act, disp_d;
  logic [1:0] r_d, g_d, b_d;

  // The first enabled edge out of pre-start loads (0,0) without advancing.
  always_comb begin
    state_d = state_q;
    h_d     = hpos;
    v_d     = vpos;
    f_d     = frame_cnt;
    load    = 1'b0;
    if (ena) begin
      load    = 1'b1;
      state_d = ST_RUN;
      if (state_q == ST_RUN) begin
        if (hpos == H_LAST) begin
          h_d = '0;
          if (vpos == V_LAST) begin
            v_d = '0;
            f_d = frame_cnt + 8'd1;
          end else begin
            v_d = vpos + 10'd1;
          end
        end else begin
          h_d = hpos + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hs_act = (h_d >= HS_BEG) && (h_d < HS_END);
    vs_act = (v_d >= VS_BEG) && (v_d < VS_END);
    disp_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

`ifdef VGA_PATTERN_EN
  logic [1:0] pat_q, pat_d;
  logic [6:0] bar_px_q, bar_px_d;
  logic [2:0] bar_k_q, bar_k_d;

  // Bar index tracks the upcoming position; it only ever steps by one pixel when not at hpos 0.
  always_comb begin
    pat_d    = pat_q;
    bar_px_d = bar_px_q;
    bar_k_d  = bar_k_q;
    if (load) begin
      if (h_d == 10'd0) begin
        bar_px_d = '0;
        bar_k_d  = '0;
        if (v_d == 10'd0) begin
          pat_d = pattern_sel;
        end
      end else if (bar_px_q == 7'd79) begin
        bar_px_d = '0;
        bar_k_d  = bar_k_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 7'd1;
      end
    end
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (disp_d) begin
      case (pat_d)
        2'd1: begin
          r_d = {2{bar_k_d[2]}};
          g_d = {2{bar_k_d[1]}};
          b_d = {2{bar_k_d[0]}};
        end
        2'd2: begin
          r_d = {2{h_d[5] ^ v_d[5]}};
          g_d = {2{h_d[5] ^ v_d[5]}};
          b_d = {2{h_d[5] ^ v_d[5]}};
        end
        2'd3: begin
          r_d = 2'((h_d[7:0] + f_d) >> 6);
          g_d = v_d[7:6];
          b_d = f_d[7:6];
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= '0;
      bar_px_q <= '0;
      bar_k_q  <= '0;
    end else begin
      pat_q    <= pat_d;
      bar_px_q <= bar_px_d;
      bar_k_q  <= bar_k_d;
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;
  assign r_d = '0;
  assign g_d = '0;
  assign b_d = '0;
`endif

  // Every output is decoded from the next position so all of them describe the same pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PRESTART;
      hpos        <= '0;
      vpos        <= '0;
      frame_cnt   <= '0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_byte    <= {3'b000, SYNC_IDLE, 3'b000, SYNC_IDLE};
    end else begin
      state_q   <= state_d;
      hpos      <= h_d;
      vpos      <= v_d;
      frame_cnt <= f_d;
      if (load) begin
        hsync       <= SYNC_IDLE ^ hs_act;
        vsync       <= SYNC_IDLE ^ vs_act;
        display_on  <= disp_d;
        line_start  <= (h_d == 10'd0);
        frame_start <= (h_d == 10'd0) && (v_d == 10'd0);
        pix_byte    <= {r_d[1], g_d[1], b_d[1], SYNC_IDLE ^ vs_act,
                        r_d[0], g_d[0], b_d[0], SYNC_IDLE ^ hs_act};
      end
    end
  end

endmodule
